uart_tx_sched: RTL and testbench



---
 rtl/uart_tx_sched.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: buffers processor writes in a FIFO and drives the tx_engine load/txrdy handshake.
// Optional flow control: define UART_TX_CTS_EN to add the active-low cts_n input gating new loads.
module uart_tx_sched #(
    parameter int          DEPTH   = 16,
    parameter int          AW      = 4,
    parameter logic [15:0] TX_PORT = 16'h0000,
    parameter int          BUSY_TO = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   port_id,
    input  logic [7:0]    out_port,
    input  logic          write_strobe,
    input  logic          err_clr,
    input  logic          txrdy,
`ifdef UART_TX_CTS_EN
    input  logic          cts_n,
`endif
    output logic          load,
    output logic [7:0]    tx_data,
    output logic [AW:0]   fifo_count,
    output logic          full,
    output logic          empty,
    output logic          ovf_err,
    output logic          tx_drain
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_RDY  = 2'd3
    } state_t;

    localparam int            BW        = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
    localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_TO - 1);
    localparam logic [BW-1:0] BUSY_ONE  = BW'(1);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [BW-1:0] busy_cnt_q, busy_cnt_d;
    logic          load_q, load_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_err_q, ovf_err_d;
    logic          tx_drain_q, tx_drain_d;
    logic [7:0]    mem_q [DEPTH];

    logic          wr_s;
    logic          do_wr_s;
    logic          do_rd_s;
    logic          cts_ok_s;

    // A full FIFO drops the write even if a dequeue happens in the same cycle.
    assign wr_s    = write_strobe && (port_id == TX_PORT);
    assign do_wr_s = wr_s && !full_q;
    assign do_rd_s = (state_q == LOAD);

`ifdef UART_TX_CTS_EN
    assign cts_ok_s = ~cts_n;
`else
    assign cts_ok_s = 1'b1;
`endif

    // FIFO pointer, occupancy and overflow next-state logic.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        ovf_err_d = ovf_err_q;
        if (do_wr_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (do_rd_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
        case ({do_wr_s, do_rd_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (wr_s && full_q) begin
            ovf_err_d = 1'b1;
        end else if (err_clr) begin
            ovf_err_d = 1'b0;
        end else begin
            ovf_err_d = ovf_err_q;
        end
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == {(AW+1){1'b0}});
    end

    // Handshake sequencer next-state; load and tx_data are set on entry to LOAD so they are registered.
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        load_d     = 1'b0;
        tx_data_d  = tx_data_q;
        tx_drain_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q && txrdy && cts_ok_s) begin
                    state_d   = LOAD;
                    load_d    = 1'b1;
                    tx_data_d = mem_q[rptr_q];
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d    = WAIT_BUSY;
                busy_cnt_d = {BW{1'b0}};
            end
            WAIT_BUSY: begin
                // An engine that never drops txrdy must not stall the queue forever.
                if (!txrdy) begin
                    state_d = WAIT_RDY;
                end else if (busy_cnt_q == BUSY_LAST) begin
                    state_d = IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q + BUSY_ONE;
                end
            end
            WAIT_RDY: begin
                if (txrdy) begin
                    state_d    = IDLE;
                    tx_drain_d = empty_q;
                end else begin
                    state_d = WAIT_RDY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO storage write port; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr_s && !reset) begin
            mem_q[wptr_q] <= out_port;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wptr_q     <= {AW{1'b0}};
            rptr_q     <= {AW{1'b0}};
            count_q    <= {(AW+1){1'b0}};
            busy_cnt_q <= {BW{1'b0}};
            load_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_err_q  <= 1'b0;
            tx_drain_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            busy_cnt_q <= busy_cnt_d;
            load_q     <= load_d;
            tx_data_q  <= tx_data_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_err_q  <= ovf_err_d;
            tx_drain_q <= tx_drain_d;
        end
    end

    assign load       = load_q;
    assign tx_data    = tx_data_q;
    assign fifo_count = count_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign ovf_err    = ovf_err_q;
    assign tx_drain   = tx_drain_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: scoreboard of enqueued bytes against bytes seen on load,
// plus a simple tx_engine model that drops txrdy for a programmable time after each load.
`timescale 1ns/1ps
module tb_uart_tx_sched;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   port_id;
    logic [7:0]    out_port;
    logic          write_strobe;
    logic          err_clr;
    logic          txrdy;
`ifdef UART_TX_CTS_EN
    logic          cts_n;
`endif
    logic          load;
    logic [7:0]    tx_data;
    logic [AW:0]   fifo_count;
    logic          full;
    logic          empty;
    logic          ovf_err;
    logic          tx_drain;

    uart_tx_sched #(.DEPTH(DEPTH), .AW(AW), .TX_PORT(16'h0000), .BUSY_TO(8)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .err_clr(err_clr), .txrdy(txrdy),
`ifdef UART_TX_CTS_EN
        .cts_n(cts_n),
`endif
        .load(load), .tx_data(tx_data), .fifo_count(fifo_count), .full(full),
        .empty(empty), .ovf_err(ovf_err), .tx_drain(tx_drain)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         load_cyc_q[$];
    int         load_total  = 0;
    int         drain_total = 0;
    int         viol        = 0;
    int         cyc         = 0;
    logic       prev_load   = 1'b0;
    logic       eng_on      = 1'b0;
    int         eng_len     = 3;
    int         eng_busy    = 0;

    // Advance one clock, sample outputs #1 after the edge, record loads/drains, run the engine model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (load === 1'b1) begin
            obs_q.push_back(tx_data);
            load_cyc_q.push_back(cyc);
            load_total++;
            if (prev_load) viol++;
            if (txrdy !== 1'b1) viol++;
        end
        if (tx_drain === 1'b1) drain_total++;
        prev_load = (load === 1'b1);
        if (eng_on) begin
            if (load === 1'b1) begin
                eng_busy = eng_len;
                txrdy    = 1'b0;
            end else if (eng_busy > 0) begin
                eng_busy--;
                if (eng_busy == 0) txrdy = 1'b1;
            end
        end
    endtask

    task automatic do_write(input logic [7:0] b);
        port_id      = 16'h0000;
        out_port     = b;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; port_id = 16'h0000; out_port = 8'h00; write_strobe = 1'b0;
        err_clr = 1'b0; txrdy = 1'b1; eng_on = 1'b0;
`ifdef UART_TX_CTS_EN
        cts_n = 1'b0;
`endif
        tick(); tick();
        n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %0b want 0", load); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", full); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b want 1", empty); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", ovf_err); end
        n_checks++; if (tx_drain !== 1'b0) begin n_fail++; $display("FAIL reset_drain: got %0b want 0", tx_drain); end
        reset = 1'b0;
        port_id = 16'h0001; out_port = 8'h99; write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0; port_id = 16'h0000;
        tick();
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL other_port_count: got %0d want 0", fifo_count); end
        n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL other_port_load: got %0b want 0", load); end
    endtask

    task automatic test_single();
        int d0;
        logic [7:0] o, e;
        d0 = drain_total;
        eng_on = 1'b1; eng_len = 100; eng_busy = 0; txrdy = 1'b1;
        exp_q.push_back(8'h41);
        do_write(8'h41);
        n_checks++; if (fifo_count !== 5'd1) begin n_fail++; $display("FAIL single_count1: got %0d want 1", fifo_count); end
        n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL single_early_load: got %0b want 0", load); end
        tick();
        n_checks++; if (load !== 1'b1) begin n_fail++; $display("FAIL single_load: got %0b want 1", load); end
        n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_tx_data: got %h want 41", tx_data); end
        tick();
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL single_count0: got %0d want 0", fifo_count); end
        for (int i = 0; i < 130; i++) tick();
        n_checks++; if (drain_total - d0 !== 1) begin n_fail++; $display("FAIL single_drain: got %0d pulses want 1", drain_total - d0); end
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL single_nbytes: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL single_byte: got %h want %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_burst_fill();
        int l0;
        l0 = load_total;
        eng_on = 1'b0; txrdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            do_write(8'(i));
        end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL burst_full: got %0b want 1", full); end
        n_checks++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL burst_count: got %0d want 16", fifo_count); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL burst_empty: got %0b want 0", empty); end
        n_checks++; if (load_total !== l0) begin n_fail++; $display("FAIL burst_no_load: got %0d loads want 0", load_total - l0); end
    endtask

    task automatic test_overflow();
        do_write(8'hAA);
        n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b want 1", ovf_err); end
        n_checks++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", fifo_count); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b want 0", ovf_err); end
        err_clr = 1'b1; do_write(8'hAA); err_clr = 1'b0;
        n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %0b want 1", ovf_err); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear2: got %0b want 0", ovf_err); end
    endtask

    task automatic test_burst_drain();
        int l0, d0;
        logic [7:0] o, e;
        l0 = load_total; d0 = drain_total;
        eng_on = 1'b1; eng_len = 3; eng_busy = 0; txrdy = 1'b1;
        for (int i = 0; i < 400 && load_total - l0 < 16; i++) tick();
        for (int i = 0; i < 12; i++) tick();
        n_checks++; if (load_total - l0 !== 16) begin n_fail++; $display("FAIL drain_loads: got %0d want 16", load_total - l0); end
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL drain_protocol: got %0d violations want 0", viol); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %0b want 1", empty); end
        n_checks++; if (drain_total - d0 !== 1) begin n_fail++; $display("FAIL drain_pulse: got %0d want 1", drain_total - d0); end
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL drain_nbytes: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL drain_byte: got %h want %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_simul_15();
        int l0;
        logic [7:0] o, e;
        eng_on = 1'b0; txrdy = 1'b0;
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(8'(32 + i));
            do_write(8'(32 + i));
        end
        n_checks++; if (fifo_count !== 5'd15) begin n_fail++; $display("FAIL sim15_pre: got %0d want 15", fifo_count); end
        l0 = load_total;
        eng_on = 1'b1; eng_len = 3; eng_busy = 0; txrdy = 1'b1;
        tick();
        n_checks++; if (load !== 1'b1) begin n_fail++; $display("FAIL sim15_load: got %0b want 1", load); end
        exp_q.push_back(8'h2F);
        do_write(8'h2F);
        n_checks++; if (fifo_count !== 5'd15) begin n_fail++; $display("FAIL sim15_count: got %0d want 15", fifo_count); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL sim15_ovf: got %0b want 0", ovf_err); end
        for (int i = 0; i < 400 && load_total - l0 < 16; i++) tick();
        for (int i = 0; i < 12; i++) tick();
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL sim15_nbytes: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL sim15_byte: got %h want %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_simul_16();
        int l0;
        logic [7:0] o, e;
        eng_on = 1'b0; txrdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(48 + i));
            do_write(8'(48 + i));
        end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL sim16_full: got %0b want 1", full); end
        l0 = load_total;
        eng_on = 1'b1; eng_len = 3; eng_busy = 0; txrdy = 1'b1;
        tick();
        n_checks++; if (load !== 1'b1) begin n_fail++; $display("FAIL sim16_load: got %0b want 1", load); end
        do_write(8'hBB);
        n_checks++; if (fifo_count !== 5'd15) begin n_fail++; $display("FAIL sim16_count: got %0d want 15", fifo_count); end
        n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL sim16_ovf: got %0b want 1", ovf_err); end
        for (int i = 0; i < 400 && load_total - l0 < 16; i++) tick();
        for (int i = 0; i < 12; i++) tick();
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL sim16_nbytes: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL sim16_byte: got %h want %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    task automatic test_busy_timeout();
        int l0;
        logic [7:0] o, e;
        eng_on = 1'b0; txrdy = 1'b1;
        l0 = load_total;
        load_cyc_q.delete();
        exp_q.push_back(8'h50); do_write(8'h50);
        exp_q.push_back(8'h51); do_write(8'h51);
        for (int i = 0; i < 60; i++) tick();
        n_checks++; if (load_total - l0 !== 2) begin n_fail++; $display("FAIL busy_to_loads: got %0d want 2", load_total - l0); end
        n_checks++;
        if (load_cyc_q.size() !== 2) begin
            n_fail++; $display("FAIL busy_to_gap: got %0d loads, cannot measure gap of 10", load_cyc_q.size());
        end else if (load_cyc_q[1] - load_cyc_q[0] !== 10) begin
            n_fail++; $display("FAIL busy_to_gap: got %0d cycles want 10", load_cyc_q[1] - load_cyc_q[0]);
        end
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL busy_to_protocol: got %0d violations want 0", viol); end
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL busy_to_count: got %0d want 0", fifo_count); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL busy_to_byte: got %h want %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int l0;
        eng_on = 1'b0; txrdy = 1'b0;
        for (int i = 0; i < 6; i++) do_write(8'(96 + i));
        txrdy = 1'b1;
        tick();
        n_checks++; if (load !== 1'b1) begin n_fail++; $display("FAIL rst_mid_load: got %0b want 1", load); end
        txrdy = 1'b0;
        tick(); tick();
        n_checks++; if (fifo_count !== 5'd5) begin n_fail++; $display("FAIL rst_mid_pre: got %0d want 5", fifo_count); end
        reset = 1'b1; tick(); reset = 1'b0;
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", fifo_count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_empty: got %0b want 1", empty); end
        n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL rst_mid_load0: got %0b want 0", load); end
        l0 = load_total;
        txrdy = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        n_checks++; if (load_total !== l0) begin n_fail++; $display("FAIL rst_mid_noload: got %0d loads want 0", load_total - l0); end
        obs_q.delete(); exp_q.delete();
    endtask

`ifdef UART_TX_CTS_EN
    task automatic test_cts();
        int l0;
        logic [7:0] o, e;
        reset = 1'b1; tick(); reset = 1'b0;
        cts_n = 1'b1;
        eng_on = 1'b1; eng_len = 3; eng_busy = 0; txrdy = 1'b1;
        l0 = load_total;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'(112 + i));
            do_write(8'(112 + i));
        end
        for (int i = 0; i < 20; i++) tick();
        n_checks++; if (load_total !== l0) begin n_fail++; $display("FAIL cts_block: got %0d loads want 0", load_total - l0); end
        n_checks++; if (fifo_count !== 5'd3) begin n_fail++; $display("FAIL cts_count: got %0d want 3", fifo_count); end
        cts_n = 1'b0;
        for (int i = 0; i < 200 && load_total - l0 < 3; i++) tick();
        for (int i = 0; i < 12; i++) tick();
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL cts_nbytes: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL cts_byte: got %h want %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst_fill();
        test_overflow();
        test_burst_drain();
        test_simul_15();
        test_simul_16();
        test_busy_timeout();
        test_reset_mid();
`ifdef UART_TX_CTS_EN
        test_cts();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
